// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, round register mux select,
// 64-round index and H0..H7 feed-forward digest across multi-block messages.
module sha256_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    input  logic         blk_first,
    output logic         blk_ready,
    output logic         ws_load,
    output logic [1:0]   rnd_sel,
    output logic [5:0]   round_idx,
    input  logic [255:0] st_in,
    output logic [255:0] dig_out,
    output logic         dig_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [1:0] SEL_HOLD     = 2'b00;
    localparam logic [1:0] SEL_LOAD     = 2'b01;
    localparam logic [1:0] SEL_COMPRESS = 2'b10;

    state_t       state;
    state_t       state_nx;
    logic [255:0] dig_sum;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (blk_valid) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_ROUND;
            S_ROUND: if (round_idx == 6'd63) state_nx = S_FINAL;
            S_FINAL: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Held low during reset so nothing is accepted before the digest is defined
    assign blk_ready = rst_n & (state == S_IDLE);
    assign ws_load   = blk_ready & blk_valid;

    // Per-word modulo-2^32 feed-forward; carries stay inside each word
    always_comb begin
        dig_sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            dig_sum[i*32 +: 32] = dig_out[i*32 +: 32] + st_in[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            round_idx <= '0;
            rnd_sel   <= SEL_HOLD;
            busy      <= 1'b0;
            dig_valid <= 1'b0;
            dig_out   <= '0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != S_IDLE);
            dig_valid <= (state == S_FINAL);

            case (state_nx)
                S_LOAD:  rnd_sel <= SEL_LOAD;
                S_ROUND: rnd_sel <= SEL_COMPRESS;
                default: rnd_sel <= SEL_HOLD;
            endcase

            if (state == S_ROUND && state_nx == S_ROUND)
                round_idx <= round_idx + 6'd1;
            else
                round_idx <= '0;

            if (ws_load && blk_first)
                dig_out <= IV;
            else if (state == S_FINAL)
                dig_out <= dig_sum;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: cycle-exact sequencing, feed-forward
// against a word-add model, handshake/reset behaviour and a full "abc" hash.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_ready;
    logic         ws_load;
    logic [1:0]   rnd_sel;
    logic [5:0]   round_idx;
    logic [255:0] st_in;
    logic [255:0] dig_out;
    logic         dig_valid;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] IV_WRAP = {
        32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
        32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18
    };
    localparam logic [255:0] ABC_DIGEST = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Bench-side round register bank and message schedule
    logic         use_bank;
    logic [255:0] force_val;
    logic [255:0] bank;
    logic [31:0]  w [64];
    logic [31:0]  msg [16];
    logic [255:0] model_dig;

    assign st_in = use_bank ? bank : force_val;

    sha256_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_first (blk_first),
        .blk_ready (blk_ready),
        .ws_load   (ws_load),
        .rnd_sel   (rnd_sel),
        .round_idx (round_idx),
        .st_in     (st_in),
        .dig_out   (dig_out),
        .dig_valid (dig_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] kw);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + kw;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) begin
        case (rnd_sel)
            2'b01:   bank <= dig_out;
            2'b10:   bank <= sha_round(bank, K[round_idx] + w[round_idx]);
            default: bank <= bank;
        endcase
    end

    task automatic build_sched();
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is just past a negedge; returns in the dig_valid cycle (no extra wait)
    task automatic run_block(input bit first, input logic [255:0] sv, input bit bank_mode,
                             input bit hold, input bit known, input logic [255:0] known_val);
        logic [255:0] base, expv;
        base      = first ? IV : model_dig;
        use_bank  = bank_mode;
        force_val = sv;
        expv      = known ? known_val : add8(base, sv);
        for (int c = 0; c <= 67; c++) begin
            if (c == 0) begin
                blk_valid = 1'b1;
                blk_first = first;
                #1;
                chk("accept_ws_load", ws_load, 1);
                chk("accept_ready", blk_ready, 1);
                chk("accept_busy", busy, 0);
            end else if (c <= 66) begin
                blk_valid = hold ? 1'b1 : ((c < 66) ? 1'($urandom) : 1'b0);
                blk_first = 1'($urandom);
                #1;
                chk("busy_ws_load", ws_load, 0);
                chk("busy_flag", busy, 1);
                chk("busy_ready", blk_ready, 0);
                chk("busy_dig_valid", dig_valid, 0);
                if (c == 1) begin
                    chk("load_sel", rnd_sel, 2'b01);
                    chk("load_digest", dig_out, base);
                end else if (c <= 65) begin
                    chk("round_sel", rnd_sel, 2'b10);
                    chk("round_idx", round_idx, c - 2);
                end else begin
                    chk("final_sel", rnd_sel, 2'b00);
                    chk("final_idx", round_idx, 0);
                end
            end else begin
                blk_valid = hold;
                #1;
                chk("done_valid", dig_valid, 1);
                chk("done_digest", dig_out, expv);
                chk("done_ready", blk_ready, 1);
                chk("done_busy", busy, 0);
                chk("done_ws_load", ws_load, hold);
            end
            if (c < 67) @(negedge clk);
        end
        model_dig = expv;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            blk_valid = 1'b0;
            blk_first = 1'($urandom);
            #1;
            chk("idle_ready", blk_ready, 1);
            chk("idle_ws_load", ws_load, 0);
            chk("idle_busy", busy, 0);
            chk("idle_dig_valid", dig_valid, 0);
            chk("idle_sel", rnd_sel, 2'b00);
            chk("idle_digest", dig_out, model_dig);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b1;
        blk_first = 1'b1;
        use_bank  = 1'b0;
        force_val = rand256();
        model_dig = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            blk_valid = (i == 0) ? 1'b1 : 1'($urandom);
            blk_first = 1'($urandom);
            force_val = rand256();
            #1;
            chk("rst_digest", dig_out, 0);
            chk("rst_sel", rnd_sel, 0);
            chk("rst_idx", round_idx, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dig_valid", dig_valid, 0);
            chk("rst_ws_load", ws_load, 0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        blk_valid = 1'b0;
        #1;
        chk("rel_ready", blk_ready, 1);
        idle_cycles(2);

        // IV load plus per-word wrap with all-ones bank contents
        @(negedge clk);
        run_block(1'b1, {8{32'hffffffff}}, 1'b0, 1'b0, 1'b1, IV_WRAP);

        // Chained block starting from the previous digest
        idle_cycles(2);
        @(negedge clk);
        run_block(1'b0, {8{32'h00000001}}, 1'b0, 1'b0, 1'b0, '0);

        // Random blocks, mixing back-to-back and gapped acceptance
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap == 0) run_block(1'($urandom), rand256(), 1'b0, 1'b0, 1'b0, '0);
            else begin
                idle_cycles(gap - 1);
                @(negedge clk);
                run_block(1'($urandom), rand256(), 1'b0, 1'b0, 1'b0, '0);
            end
        end

        // blk_valid held high: next accept lands in the dig_valid cycle
        idle_cycles(1);
        @(negedge clk);
        run_block(1'b1, rand256(), 1'b0, 1'b1, 1'b0, '0);
        run_block(1'b0, rand256(), 1'b0, 1'b0, 1'b0, '0);
        idle_cycles(1);

        // Reset pulse in the middle of the rounds
        @(negedge clk);
        blk_valid = 1'b1;
        blk_first = 1'b1;
        force_val = rand256();
        for (int n = 0; n < 40 && round_idx !== 6'd30; n++) @(negedge clk);
        chk("reach_idx30", round_idx, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_idx", round_idx, 0);
        chk("midrst_sel", rnd_sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_digest", dig_out, 0);
        chk("midrst_dig_valid", dig_valid, 0);
        @(negedge clk);
        blk_valid = 1'b0;
        rst_n     = 1'b1;
        model_dig = '0;
        idle_cycles(70);

        // Full hash of padded "abc" through the bench round logic and bank
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_sched();
        @(negedge clk);
        run_block(1'b1, '0, 1'b1, 1'b0, 1'b1, ABC_DIGEST);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
